adc_acq_sched: RTL and testbench

//  Acquisition scheduler for the two ADC channels on the CSR bus. CPU writes one config and a start pulse.

---
 rtl/adc_acq_sched.sv | 198 +++++++++++++++++++
 tb/tb_adc_acq_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_acq_sched.sv
// Round-robin acquisition scheduler for ADC1/ADC2: one write per enabled channel per round, fixed us period.
// Optional ack watchdog enabled by defining ADC_SCHED_WDOG_EN.
module adc_acq_sched #(
    parameter int CLK_MHZ = 27,
    parameter int ACK_TMO = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic [1:0]  cfg_en,
    input  logic        cfg_test,
    input  logic [14:0] cfg_time_us,
    input  logic [15:0] cfg_period_us,
    input  logic [7:0]  cfg_rounds,
    output logic        adc1_tx_write,
    output logic        adc1_tx_test,
    output logic [14:0] adc1_tx_time_us,
    input  logic        adc1_tx_busy,
    output logic        adc2_tx_write,
    output logic        adc2_tx_test,
    output logic [14:0] adc2_tx_time_us,
    input  logic        adc2_tx_busy,
    output logic        sched_busy,
    output logic        sched_done,
    output logic [7:0]  round_cnt,
    output logic        overrun,
    output logic        tmo_err
);

    localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

    // states: IDLE idle | ISSUE send write | WAIT_ACK await busy=1 | WAIT_DONE await busy=0 | GAP wait period
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_GAP} state_t;

    state_t        state, state_nxt;
    logic          ch, ch_nxt;
    logic [PW-1:0] presc;
    logic [15:0]   cnt_us;
    logic [1:0]    sh_en;
    logic          sh_test;
    logic [14:0]   sh_time;
    logic [15:0]   sh_period;
    logic [7:0]    sh_rounds;
    logic          stop_pend, wr1_q, wr2_q, done_q;
    logic          wr1_nxt, wr2_nxt, ch_done, rnd_inc, ovr_set, cnt_clr;
    logic          start_ok, stop_now, tick, bsy, first_ch, last_ch, round_fin, period_hit, wd_exp;
    logic [7:0]    rc_inc;
    logic [16:0]   cnt_eff;

    assign start_ok   = cfg_start && (state == S_IDLE) && (cfg_en != 2'b00);
    assign stop_now   = stop_pend | cfg_stop;
    assign tick       = (state != S_IDLE) && (presc == PW'(CLK_MHZ - 1));
    assign bsy        = ch ? adc2_tx_busy : adc1_tx_busy;
    assign first_ch   = ~sh_en[0];
    assign last_ch    = ch | ~sh_en[1];
    assign rc_inc     = round_cnt + 8'd1;
    assign round_fin  = stop_now | ((sh_rounds != 8'd0) && (rc_inc == sh_rounds));
    // Include the tick landing this cycle so the next round starts exactly on the us boundary.
    assign cnt_eff    = {1'b0, cnt_us} + {16'd0, tick};
    assign period_hit = cnt_eff >= {1'b0, sh_period};

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        wr1_nxt   = 1'b0;
        wr2_nxt   = 1'b0;
        ch_done   = 1'b0;
        rnd_inc   = 1'b0;
        ovr_set   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_ISSUE;
                    ch_nxt    = ~cfg_en[0];
                end
            end
            S_ISSUE: begin
                if (stop_now) begin
                    state_nxt = S_IDLE;
                end else if (!bsy) begin
                    wr1_nxt   = ~ch;
                    wr2_nxt   = ch;
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (bsy) state_nxt = S_WAIT_DONE;
                else if (wd_exp) ch_done = 1'b1;
            end
            S_WAIT_DONE: begin
                if (!bsy) ch_done = 1'b1;
            end
            S_GAP: begin
                if (stop_now) begin
                    state_nxt = S_IDLE;
                end else if (period_hit) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_ISSUE;
                    ch_nxt    = first_ch;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (ch_done) begin
            if (!last_ch) begin
                state_nxt = stop_now ? S_IDLE : S_ISSUE;
                ch_nxt    = 1'b1;
            end else begin
                rnd_inc = 1'b1;
                ovr_set = period_hit && (sh_period != 16'd0);
                if (round_fin) begin
                    state_nxt = S_IDLE;
                end else if (period_hit) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_ISSUE;
                    ch_nxt    = first_ch;
                end else begin
                    state_nxt = S_GAP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ch        <= 1'b0;
            presc     <= '0;
            cnt_us    <= '0;
            sh_en     <= '0;
            sh_test   <= 1'b0;
            sh_time   <= '0;
            sh_period <= '0;
            sh_rounds <= '0;
            stop_pend <= 1'b0;
            round_cnt <= '0;
            overrun   <= 1'b0;
            wr1_q     <= 1'b0;
            wr2_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            ch     <= ch_nxt;
            wr1_q  <= wr1_nxt;
            wr2_q  <= wr2_nxt;
            done_q <= (state != S_IDLE) && (state_nxt == S_IDLE);
            if (start_ok) presc <= '0;
            else if (state != S_IDLE) presc <= tick ? '0 : presc + PW'(1);
            if (start_ok || cnt_clr) cnt_us <= '0;
            else if (tick && (cnt_us != 16'hFFFF)) cnt_us <= cnt_us + 16'd1;
            if (start_ok) begin
                sh_en     <= cfg_en;
                sh_test   <= cfg_test;
                sh_time   <= cfg_time_us;
                sh_period <= cfg_period_us;
                sh_rounds <= cfg_rounds;
            end
            if (start_ok) round_cnt <= '0;
            else if (rnd_inc) round_cnt <= rc_inc;
            if (start_ok) overrun <= 1'b0;
            else if (ovr_set) overrun <= 1'b1;
            if (state_nxt == S_IDLE) stop_pend <= 1'b0;
            else if (cfg_stop && (state != S_IDLE)) stop_pend <= 1'b1;
        end
    end

`ifdef ADC_SCHED_WDOG_EN
    localparam int WW = $clog2(ACK_TMO + 1);
    logic [WW-1:0] wd;

    assign wd_exp = (wd == WW'(ACK_TMO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd      <= '0;
            tmo_err <= 1'b0;
        end else begin
            wd <= (state == S_WAIT_ACK) ? wd + WW'(1) : '0;
            if ((state == S_WAIT_ACK) && !bsy && wd_exp) tmo_err <= 1'b1;
        end
    end
`else
    assign wd_exp  = 1'b0;
    assign tmo_err = 1'b0;
`endif

    assign adc1_tx_write   = wr1_q;
    assign adc2_tx_write   = wr2_q;
    assign adc1_tx_test    = sh_test;
    assign adc2_tx_test    = sh_test;
    assign adc1_tx_time_us = sh_time;
    assign adc2_tx_time_us = sh_time;
    assign sched_busy      = (state != S_IDLE);
    assign sched_done      = done_q;

endmodule

// File: tb/tb_adc_acq_sched.sv
// Randomized bench for adc_acq_sched: busy-handshake ADC models plus a round/order/timing reference model.
// Define ADC_SCHED_WDOG_EN to also exercise the ack watchdog.
module tb_adc_acq_sched;

    localparam int CLK_MHZ = 27;
    localparam int ACK_TMO = 64;

    logic        clk = 1'b0;
    logic        rst, cfg_start, cfg_stop, cfg_test;
    logic [1:0]  cfg_en;
    logic [14:0] cfg_time_us;
    logic [15:0] cfg_period_us;
    logic [7:0]  cfg_rounds;
    logic        adc1_tx_write, adc1_tx_test, adc1_tx_busy;
    logic        adc2_tx_write, adc2_tx_test, adc2_tx_busy;
    logic [14:0] adc1_tx_time_us, adc2_tx_time_us;
    logic        sched_busy, sched_done, overrun, tmo_err;
    logic [7:0]  round_cnt;

    int n_chk = 0, n_err = 0, cyc = 0;
    int wr_ch[$];
    int wr_cyc[$];
    int done_cnt = 0, both_cnt = 0, last_fall1 = 0, tmo_cyc = -1;
    int busy_len = 270, ack_dly = 1;
    bit noack1 = 1'b0, refill_chk = 1'b0, busy1_q = 1'b0;
    logic [14:0] exp_time = '0;
    logic        exp_test = 1'b0;

    adc_acq_sched #(.CLK_MHZ(CLK_MHZ), .ACK_TMO(ACK_TMO)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_en(cfg_en),
        .cfg_test(cfg_test), .cfg_time_us(cfg_time_us), .cfg_period_us(cfg_period_us),
        .cfg_rounds(cfg_rounds),
        .adc1_tx_write(adc1_tx_write), .adc1_tx_test(adc1_tx_test),
        .adc1_tx_time_us(adc1_tx_time_us), .adc1_tx_busy(adc1_tx_busy),
        .adc2_tx_write(adc2_tx_write), .adc2_tx_test(adc2_tx_test),
        .adc2_tx_time_us(adc2_tx_time_us), .adc2_tx_busy(adc2_tx_busy),
        .sched_busy(sched_busy), .sched_done(sched_done), .round_cnt(round_cnt),
        .overrun(overrun), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ADC peripheral models: busy rises ack_dly cycles after a write and lasts busy_len cycles.
    initial begin
        adc1_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (adc1_tx_write && !noack1) begin
                repeat (ack_dly) @(posedge clk);
                #1 adc1_tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 adc1_tx_busy = 1'b0;
            end
        end
    end

    initial begin
        adc2_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (adc2_tx_write) begin
                repeat (ack_dly) @(posedge clk);
                #1 adc2_tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 adc2_tx_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (adc1_tx_write || adc2_tx_write) begin
            if (adc1_tx_write && adc2_tx_write) both_cnt++;
            wr_ch.push_back(adc1_tx_write ? 1 : 2);
            wr_cyc.push_back(cyc);
            check_val("tx_time", adc1_tx_write ? adc1_tx_time_us : adc2_tx_time_us, exp_time);
            check_val("tx_test", adc1_tx_write ? adc1_tx_test : adc2_tx_test, exp_test);
            if (refill_chk && adc1_tx_write && wr_ch.size() > 1)
                check_val("refill_le2", int'((cyc - last_fall1) <= 2), 1);
        end
        if (busy1_q && !adc1_tx_busy) last_fall1 = cyc;
        busy1_q = adc1_tx_busy;
        if (sched_done) done_cnt++;
        if (tmo_err && tmo_cyc < 0) tmo_cyc = cyc;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "bench time limit");
    end

    task automatic clear_log();
        wr_ch.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic start_run(input logic [1:0] en, input int rounds, input int period,
                             input bit with_stop, input bit accept);
        @(posedge clk); #1;
        cfg_en        = en;
        cfg_rounds    = 8'(rounds);
        cfg_period_us = 16'(period);
        cfg_time_us   = 15'($urandom_range(1, 32767));
        cfg_test      = 1'($urandom);
        cfg_start     = 1'b1;
        cfg_stop      = with_stop;
        if (accept) begin
            exp_time = cfg_time_us;
            exp_test = cfg_test;
        end
        @(posedge clk); #1;
        cfg_start   = 1'b0;
        cfg_stop    = 1'b0;
        cfg_time_us = 15'($urandom);
        cfg_test    = ~cfg_test;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 cfg_stop = 1'b1;
        @(posedge clk); #1 cfg_stop = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wr_ch.size() < n && k < budget) begin @(posedge clk); k++; end
        if (wr_ch.size() < n) check_val("wr_wait_tmo", wr_ch.size(), n);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin @(posedge clk); k++; end
        #1;
        if (done_cnt == 0) check_val("done_wait_tmo", done_cnt, 1);
    endtask

    task automatic wait_busy2(input logic lvl, input int budget);
        int k = 0;
        while (adc2_tx_busy !== lvl && k < budget) begin @(posedge clk); k++; end
        if (adc2_tx_busy !== lvl) check_val("busy2_wait_tmo", adc2_tx_busy, lvl);
    endtask

    // Reference order: each round visits ADC1 then ADC2, skipping disabled ones.
    task automatic check_order(input logic [1:0] en, input int rounds);
        int exp_q[$];
        for (int r = 0; r < rounds; r++)
            for (int c = 0; c < 2; c++)
                if (en[c]) exp_q.push_back(c + 1);
        check_val("wr_count", wr_ch.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_val("wr_order", (i < wr_ch.size()) ? wr_ch[i] : -1, exp_q[i]);
    endtask

    initial begin
        int a1[$];
        int k;
        rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_en = 2'b00; cfg_test = 1'b0;
        cfg_time_us = '0; cfg_period_us = '0; cfg_rounds = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst_outs", {adc1_tx_write, adc1_tx_test, adc1_tx_time_us, adc2_tx_write,
                  adc2_tx_test, adc2_tx_time_us, sched_busy, sched_done, overrun, tmo_err}, 0);
        check_val("rst_round_cnt", round_cnt, 0);

        // 1: both channels, 3 rounds, 100 us period, 10 us conversions
        busy_len = 10 * CLK_MHZ; ack_dly = $urandom_range(1, 4);
        clear_log();
        start_run(2'b11, 3, 100, 1'b0, 1'b1);
        check_val("busy_active", sched_busy, 1);
        wait_done(12000);
        repeat (20) @(posedge clk); #1;
        check_order(2'b11, 3);
        for (int i = 0; i < wr_ch.size(); i++) if (wr_ch[i] == 1) a1.push_back(wr_cyc[i]);
        for (int i = 1; i < a1.size(); i++) check_val("spacing", a1[i] - a1[i-1], 100 * CLK_MHZ);
        check_val("t1_rounds", round_cnt, 3);
        check_val("t1_done", done_cnt, 1);
        check_val("t1_overrun", overrun, 0);
        check_val("t1_idle", sched_busy, 0);

        // 2: ADC1 only, conversions longer than the period
        busy_len = 20 * CLK_MHZ; ack_dly = $urandom_range(1, 4);
        clear_log(); refill_chk = 1'b1;
        start_run(2'b01, 4, 5, 1'b0, 1'b1);
        wait_done(5000);
        refill_chk = 1'b0;
        check_order(2'b01, 4);
        check_val("t2_overrun", overrun, 1);
        check_val("t2_rounds", round_cnt, 4);
        repeat (100) @(posedge clk);

        // 3: continuous run, stop during ADC2 conversion of round 2
        busy_len = 10 * CLK_MHZ; ack_dly = $urandom_range(1, 4);
        clear_log();
        start_run(2'b11, 0, 30, 1'b0, 1'b1);
        wait_writes(4, 4000);
        wait_busy2(1'b1, 50);
        repeat (20) @(posedge clk);
        pulse_stop();
        wait_done(600);
        check_val("t3_busy2_low", adc2_tx_busy, 0);
        check_val("t3_rounds", round_cnt, 2);
        repeat (3000) @(posedge clk); #1;
        check_order(2'b11, 2);
        check_val("t3_done", done_cnt, 1);
        check_val("t3_idle", sched_busy, 0);

        // 4a: start with nothing enabled is ignored
        clear_log();
        start_run(2'b00, 2, 10, 1'b0, 1'b0);
        repeat (200) @(posedge clk); #1;
        check_val("t4a_busy", sched_busy, 0);
        check_val("t4a_writes", wr_ch.size(), 0);
        check_val("t4a_done", done_cnt, 0);

        // 4b: start and stop together while idle -> start wins
        clear_log();
        start_run(2'b10, 1, 10, 1'b1, 1'b1);
        wait_done(1000);
        check_order(2'b10, 1);
        check_val("t4b_rounds", round_cnt, 1);
        repeat (50) @(posedge clk);

        // 4c: a second start while active changes nothing
        clear_log();
        start_run(2'b10, 2, 40, 1'b0, 1'b1);
        wait_writes(1, 100);
        start_run(2'b01, 5, 3, 1'b0, 1'b0);
        wait_done(3000);
        repeat (20) @(posedge clk); #1;
        check_order(2'b10, 2);
        check_val("t4c_rounds", round_cnt, 2);
        check_val("t4c_done", done_cnt, 1);
        check_val("t4c_shadow", adc2_tx_time_us, exp_time);

        // 4d: start and stop together during GAP -> stop wins, prompt return to idle
        clear_log();
        start_run(2'b11, 0, 40, 1'b0, 1'b1);
        wait_writes(2, 1000);
        wait_busy2(1'b1, 50);
        wait_busy2(1'b0, 600);
        repeat (5) @(posedge clk);
        start_run(2'b01, 1, 1, 1'b1, 1'b0);
        k = 0;
        while (done_cnt == 0 && k < 5) begin @(posedge clk); k++; end
        #1 check_val("t4d_done", done_cnt, 1);
        repeat (1500) @(posedge clk); #1;
        check_order(2'b11, 1);
        check_val("t4d_rounds", round_cnt, 1);

        // 5: synchronous reset in the middle of an ADC1 conversion
        clear_log();
        start_run(2'b11, 0, 50, 1'b0, 1'b1);
        k = 0;
        while (!adc1_tx_busy && k < 50) begin @(posedge clk); k++; end
        check_val("t5_busy1", adc1_tx_busy, 1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_val("t5_outs", {adc1_tx_write, adc1_tx_test, adc1_tx_time_us, adc2_tx_write,
                  adc2_tx_test, adc2_tx_time_us, sched_busy, sched_done, overrun, tmo_err}, 0);
        check_val("t5_round_cnt", round_cnt, 0);
        repeat (1500) @(posedge clk); #1;
        check_val("t5_writes", wr_ch.size(), 1);
        check_val("t5_done", done_cnt, 0);

`ifdef ADC_SCHED_WDOG_EN
        // 6: ADC1 never acknowledges -> timeout, ADC2 still served
        clear_log(); noack1 = 1'b1; tmo_cyc = -1;
        start_run(2'b11, 1, 20, 1'b0, 1'b1);
        wait_done(2000);
        noack1 = 1'b0;
        check_order(2'b11, 1);
        check_val("t6_tmo_at", (wr_cyc.size() > 0) ? tmo_cyc - wr_cyc[0] : -1, ACK_TMO);
        check_val("t6_tmo_err", tmo_err, 1);
        check_val("t6_rounds", round_cnt, 1);
`else
        check_val("tmo_never", tmo_cyc, -1);
`endif
        check_val("no_dual_write", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
